systolic_array_ctrl: RTL and testbench

- Sequencer for the weight-stationary systolic MAC array.
- Per job: pulses the array's weight-load strobe, accepts activation vectors over a valid/ready stream, and skews them diagonally onto the array input lanes.
- Deskews the array's column outputs back into aligned result vectors, tags each with a valid, and signals job completion.
- Sits between the DMA/activation buffer and the array instance.

---
 rtl/systolic_array_ctrl.sv | 163 ++++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_ctrl.sv
// Weight-stationary array sequencer: wt_load pulse, diagonal activation skew, column deskew; result latency ARR_LAT+COLS+1.
// Activations use valid/ready; results carry no backpressure. SYSTOLIC_ARRAY_CTRL_PERF_EN adds perf_cycles/perf_stalls.
module systolic_array_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int ARR_LAT      = 4,
  parameter int WLOAD_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [CNT_W-1:0]                    num_vec,
  output logic                                busy,
  output logic                                done,
  input  logic                                act_valid,
  output logic                                act_ready,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0]     act_data,
  output logic                                wt_load,
  output logic [ROWS-1:0][DATA_WIDTH-1:0]     arr_in,
  input  logic [COLS-1:0][2*DATA_WIDTH-1:0]   arr_out,
  output logic                                res_valid,
  output logic [COLS-1:0][2*DATA_WIDTH-1:0]   res_data
`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]                         perf_cycles,
  output logic [31:0]                         perf_stalls
`endif
);
  localparam int LAT  = ARR_LAT + COLS + 1;
  localparam int WL_W = 4;

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [WL_W-1:0]  wl_q, wl_d;
  logic [LAT-1:0]   vpipe_q, vpipe_d;
  logic             xfer;

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    acc_d     = acc_q;
    wl_d      = wl_q;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    wt_load   = 1'b0;
    act_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_vec;
          acc_d   = '0;
          wl_d    = '0;
          state_d = LOAD_W;
        end
      end
      LOAD_W: begin
        wt_load = 1'b1;
        wl_d    = wl_q + 1'b1;
        if (wl_q == WL_W'(WLOAD_CYCLES - 1)) state_d = (num_q == '0) ? FIN : STREAM;
      end
      STREAM: begin
        act_ready = (acc_q < num_q);
        if (act_valid && act_ready) begin
          acc_d = acc_q + 1'b1;
          if (acc_d == num_q) state_d = DRAIN;
        end
      end
      // The output stage may still hold the final result; everything upstream must be empty.
      DRAIN: if (vpipe_q[LAT-2:0] == '0) state_d = FIN;
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign xfer      = act_valid & act_ready;
  assign vpipe_d   = {vpipe_q[LAT-2:0], xfer};
  assign res_valid = vpipe_q[LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      acc_q   <= '0;
      wl_q    <= '0;
      vpipe_q <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      acc_q   <= acc_d;
      wl_q    <= wl_d;
      vpipe_q <= vpipe_d;
    end
  end

  // Lane r is delayed r+1 cycles; idle cycles inject zeros so bubbles stay inert in the array.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [DATA_WIDTH-1:0] sk_q [r+1];
    logic [DATA_WIDTH-1:0] sk_d [r+1];
    always_comb begin
      sk_d[0] = xfer ? act_data[r] : '0;
      for (int k = 1; k <= r; k++) sk_d[k] = sk_q[k-1];
    end
    always_ff @(posedge clk) begin
      for (int k = 0; k <= r; k++) sk_q[k] <= rst ? '0 : sk_d[k];
    end
    assign arr_in[r] = sk_q[r];
  end

  // Column t arrives t cycles after column 0, so it needs COLS-1-t delays plus the output register.
  for (genvar t = 0; t < COLS; t++) begin : g_deskew
    localparam int D = COLS - t;
    logic [2*DATA_WIDTH-1:0] dk_q [D];
    logic [2*DATA_WIDTH-1:0] dk_d [D];
    always_comb begin
      dk_d[0] = arr_out[t];
      for (int k = 1; k < D; k++) dk_d[k] = dk_q[k-1];
    end
    always_ff @(posedge clk) begin
      for (int k = 0; k < D; k++) dk_q[k] <= rst ? '0 : dk_d[k];
    end
    assign res_data[t] = dk_q[D-1];
  end

`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
  logic [31:0] pcyc_q, pcyc_d, pstl_q, pstl_d;

  always_comb begin
    pcyc_d = pcyc_q;
    pstl_d = pstl_q;
    if (state_q == IDLE) begin
      if (start) begin
        pcyc_d = '0;
        pstl_d = '0;
      end
    end else begin
      if (pcyc_q != '1) pcyc_d = pcyc_q + 32'd1;
      if (act_ready && !act_valid && pstl_q != '1) pstl_d = pstl_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcyc_q <= '0;
      pstl_q <= '0;
    end else begin
      pcyc_q <= pcyc_d;
      pstl_q <= pstl_d;
    end
  end

  assign perf_cycles = pcyc_q;
  assign perf_stalls = pstl_q;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Randomized bench for systolic_array_ctrl with a behavioural array model and a job-level reference model.
module tb_systolic_array_ctrl;
  localparam int DW      = 32;
  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int ARR_LAT = 4;
  localparam int CNT_W   = 16;
  localparam int L       = ARR_LAT + COLS + 1;
  localparam int W       = 1;
  localparam int W2      = 4;
  localparam int MAXC    = 8192;

  typedef logic [ROWS-1:0][DW-1:0]   vec_t;
  typedef logic [COLS-1:0][2*DW-1:0] res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, act_valid, busy, done, act_ready, wt_load, res_valid;
  logic [CNT_W-1:0] num_vec;
  vec_t             act_data, arr_in;
  res_t             arr_out, res_data;

  logic             start2, busy2, done2, act_ready2, wt_load2, res_valid2;
  logic             act_valid2 = 1'b1;
  logic [CNT_W-1:0] num_vec2;
  vec_t             act_data2 = '0;
  vec_t             arr_in2;
  res_t             arr_out2 = '0;
  res_t             res_data2;

`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_stalls, perf_cycles2, perf_stalls2;
`endif

  systolic_array_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data), .wt_load(wt_load),
    .arr_in(arr_in), .arr_out(arr_out), .res_valid(res_valid), .res_data(res_data)
`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  systolic_array_ctrl #(.WLOAD_CYCLES(W2)) dut_w4 (
    .clk(clk), .rst(rst), .start(start2), .num_vec(num_vec2), .busy(busy2), .done(done2),
    .act_valid(act_valid2), .act_ready(act_ready2), .act_data(act_data2), .wt_load(wt_load2),
    .arr_in(arr_in2), .arr_out(arr_out2), .res_valid(res_valid2), .res_data(res_data2)
`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
    , .perf_cycles(perf_cycles2), .perf_stalls(perf_stalls2)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] wgt [ROWS][COLS];
  bit          xv_vld [MAXC];
  vec_t        xv [MAXC];
  vec_t        ain_hist [MAXC];

  bit          job_on = 1'b0;
  int          s_cyc = 0, n_job = 0, acc = 0, done_cyc = -1;
  int          due_q[$];
  res_t        res_q[$];
  logic [31:0] m_pcyc = '0, m_pstl = '0;
  bit          j2_on = 1'b0;
  int          s2 = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int r = 0; r < ROWS; r++) v[r] = $urandom;
    return v;
  endfunction

  // Result vector = activation vector times the stationary weight matrix.
  function automatic res_t dot(input vec_t x);
    res_t o;
    for (int t = 0; t < COLS; t++) begin
      o[t] = '0;
      for (int r = 0; r < ROWS; r++) o[t] += 64'(x[r]) * 64'(wgt[r][t]);
    end
    return o;
  endfunction

  function automatic bit m_ready();
    return job_on && (cyc >= s_cyc + 1 + W) && (acc < n_job);
  endfunction

  task automatic step();
    bit   exp_rv, rdy;
    vec_t exp_ain;
    int   j;
    if (cyc >= MAXC - 16) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 16);
      $fatal(1, "cycle budget exhausted");
    end
    // Array model: column t at cycle k sums lane r as presented at k-ARR_LAT-t+r.
    for (int t = 0; t < COLS; t++) begin
      arr_out[t] = '0;
      for (int r = 0; r < ROWS; r++) begin
        j = cyc - ARR_LAT - t + r;
        if (j >= 0) arr_out[t] += 64'(ain_hist[j][r]) * 64'(wgt[r][t]);
      end
    end
    #1;
    exp_rv = (due_q.size() > 0) && (due_q[0] == cyc);
    chk("busy", busy, job_on);
    chk("wt_load", wt_load, job_on && cyc >= s_cyc + 1 && cyc <= s_cyc + W);
    chk("act_ready", act_ready, m_ready());
    chk("done", done, job_on && cyc == done_cyc);
    chk("res_valid", res_valid, exp_rv);
    if (exp_rv) chk("res_data", res_data, res_q[0]);
    for (int r = 0; r < ROWS; r++) begin
      j = cyc - 1 - r;
      exp_ain[r] = (j >= 0 && xv_vld[j]) ? xv[j][r] : '0;
    end
    chk("arr_in", arr_in, exp_ain);
    chk("busy2", busy2, j2_on && cyc >= s2 + 1 && cyc <= s2 + W2 + 1);
    chk("wt_load2", wt_load2, j2_on && cyc >= s2 + 1 && cyc <= s2 + W2);
    chk("done2", done2, j2_on && cyc == s2 + W2 + 1);
    chk("act_ready2", act_ready2, 1'b0);
    chk("res_valid2", res_valid2, 1'b0);
    chk("arr_in2", arr_in2, '0);
    chk("res_data2", res_data2, '0);
`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, m_pcyc);
    chk("perf_stalls", perf_stalls, m_pstl);
    chk("perf_cycles2", perf_cycles2, (j2_on && cyc > s2) ? ((cyc - s2 - 1 < W2 + 1) ? cyc - s2 - 1 : W2 + 1) : 0);
    chk("perf_stalls2", perf_stalls2, '0);
`endif
    ain_hist[cyc] = arr_in;

    if (exp_rv) begin
      void'(due_q.pop_front());
      void'(res_q.pop_front());
    end
    if (rst) begin
      job_on   = 1'b0;
      acc      = 0;
      done_cyc = -1;
      m_pcyc   = '0;
      m_pstl   = '0;
      j2_on    = 1'b0;
      due_q.delete();
      res_q.delete();
      for (int k = cyc - ROWS; k <= cyc; k++) if (k >= 0) xv_vld[k] = 1'b0;
    end else begin
      rdy = m_ready();
      if (rdy && act_valid) begin
        xv_vld[cyc] = 1'b1;
        xv[cyc]     = act_data;
        due_q.push_back(cyc + L);
        res_q.push_back(dot(act_data));
        acc++;
        if (acc == n_job) done_cyc = cyc + L + 1;
      end
      if (rdy && !act_valid && m_pstl != '1) m_pstl++;
      if (job_on && m_pcyc != '1) m_pcyc++;
      if (job_on && cyc == done_cyc) job_on = 1'b0;
      else if (!job_on && start) begin
        job_on   = 1'b1;
        s_cyc    = cyc;
        n_job    = int'(num_vec);
        acc      = 0;
        m_pcyc   = '0;
        m_pstl   = '0;
        done_cyc = (num_vec == 0) ? cyc + W + 1 : -1;
      end
      if (start2 && !j2_on) begin
        j2_on = 1'b1;
        s2    = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int k);
    start     = 1'b0;
    act_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      act_data = rand_vec();
      step();
    end
  endtask

  // mode 0: valid held high, 1: random valid, 2: one transfer every 4 stream cycles,
  // 3: random valid with stray start pulses, 4: fixed {1,2,3,4} vector
  task automatic run_job(input int n, input int mode, input int rst_at);
    int lim;
    bit rst_fired;
    vec_t skv;
    for (int r = 0; r < ROWS; r++) skv[r] = DW'(r + 1);
    rst_fired = 1'b0;
    start     = 1'b1;
    num_vec   = CNT_W'(n);
    act_valid = 1'b0;
    act_data  = rand_vec();
    step();
    start = 1'b0;
    lim   = 0;
    while (job_on && lim < 400) begin
      case (mode)
        0:       act_valid = 1'b1;
        2:       act_valid = ((cyc - (s_cyc + 1 + W)) % 4 == 0);
        4:       act_valid = 1'b1;
        default: act_valid = ($urandom_range(0, 2) != 0);
      endcase
      act_data = (mode == 4) ? skv : rand_vec();
      start    = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      num_vec  = CNT_W'($urandom);
      if (rst_at > 0 && !rst_fired && acc == rst_at) begin
        rst       = 1'b1;
        rst_fired = 1'b1;
      end
      step();
      rst = 1'b0;
      lim++;
    end
    start     = 1'b0;
    act_valid = 1'b0;
    chk("job_end_busy", busy, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    num_vec   = '0;
    act_valid = 1'b0;
    act_data  = '0;
    arr_out   = '0;
    start2    = 1'b0;
    num_vec2  = '0;
    for (int r = 0; r < ROWS; r++)
      for (int t = 0; t < COLS; t++) wgt[r][t] = $urandom;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    idle(2);

    start2   = 1'b1;
    num_vec2 = '0;
    step();
    start2 = 1'b0;
    idle(8);

    run_job(3, 0, 0);
    idle(3);
    run_job(2, 2, 0);
    idle(2);
    run_job(5, 3, 0);
    idle(2);
    run_job(5, 1, 2);
    idle(12);
    run_job(1, 0, 0);
    idle(2);
    run_job(1, 4, 0);
    idle(2);
    run_job(0, 1, 0);
    idle(1);
    for (int i = 0; i < 8; i++) begin
      run_job($urandom_range(1, 7), $urandom_range(0, 1), 0);
      idle($urandom_range(0, 3));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
